stopwatch_controller: RTL
=========================

Name: stopwatch_controller

Overview:
Control FSM for the Swiss timer's BCD counter chain, driving the chain's enable_Count and clear inputs and the display freeze.
- Derives the 1/TICK_HZ count tick from the system clock.
- Synchronises and edge-detects the two user buttons.
- Sequences the timer through idle, run, pause and lap-hold modes.

Parameters:
CLOCK_HZ, 50000000, system clock frequency in Hz
TICK_HZ, 100, count tick rate in Hz (hundredths of a second)
DIV, CLOCK_HZ/TICK_HZ (derived, localparam), prescaler modulus; elaboration error if DIV < 2

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
start_Stop  input  1  raw button level, active-high, asynchronous to clock
lap_Reset  input  1  raw button level, active-high, asynchronous to clock
count_Enable  output  1  one-cycle tick to the least-significant BCD counter's enable_Count
clear_Counters  output  1  one-cycle pulse to every BCD counter's clear
display_Hold  output  1  level; display latches frozen while high
timer_State  output  2  current FSM state encoding (debug/LEDs)

Behaviour:
- Reset (async assert): state IDLE; prescaler 0; synchroniser and edge flops 0; count_Enable, display_Hold, clear_Counters all 0.
- Power-on clear: on the first clock edge after reset deasserts, clear_Counters = 1 for exactly one cycle, then 0.
- Inputs: each button passes through a 2-flop synchroniser plus an edge register. A press event is a 1-cycle pulse on the synchronised 0->1 transition.
  - An input rising before edge N produces a pulse registered at edge N+2.
  - The state changes at edge N+3.
  - A held button produces exactly one event.
- States and encodings: IDLE=0, RUN=1, PAUSE=2, LAP=3.
  - IDLE: start -> RUN (prescaler forced to 0); lap -> clear_Counters pulse next cycle, stay IDLE.
  - RUN: start -> PAUSE; lap -> LAP.
  - LAP: display_Hold = 1, counting continues; lap -> RUN (hold released); start -> PAUSE (hold released).
  - PAUSE: start -> RUN (prescaler resumes from its held value, not reset); lap -> clear_Counters pulse for one cycle, next state IDLE, prescaler 0.
- Simultaneous start and lap events in the same cycle: start wins, lap is discarded.
- Prescaler: width clog2(DIV).
  - Increments only in RUN or LAP; frozen in IDLE and PAUSE.
  - At DIV-1 it wraps to 0, and count_Enable = 1 that same cycle (registered output, one cycle wide).
  - Tick period is exactly DIV cycles in uninterrupted running.
- Transition cycle: on the edge that leaves RUN/LAP for PAUSE, no tick is issued even if the prescaler is at DIV-1; the prescaler holds DIV-1 and ticks on the first RUN cycle after resume.
- display_Hold is registered and equals (state == LAP); it changes on the same edge as the state.
- clear_Counters and count_Enable are never high in the same cycle.
- Reset mid-operation: all outputs drop to 0 asynchronously; any pending events are lost; the power-on clear pulse is reissued after deassert.
- Output rules: no combinational path from inputs to outputs; all outputs are flops.

Decomposition:
- Shared package stopwatch_pkg: the state encodings (IDLE/RUN/PAUSE/LAP as 2-bit localparams) and the default TICK_HZ constant, shared with the display block that decodes timer_State.
- Sub-module button_edge_sync (2-flop synchroniser + rising-edge pulse, async reset), instantiated twice.
- The FSM and prescaler stay in stopwatch_controller.

Test Plan:
(Bench uses CLOCK_HZ=10, TICK_HZ=2, so DIV=5.)
1. Reset, then release -> clear_Counters high exactly one cycle; state IDLE; count_Enable 0 for 20 cycles.
2. Press start 1 cycle -> state RUN at the 3rd edge; count_Enable pulses every 5 cycles, first pulse 5 cycles after entering RUN; hold start 10 cycles -> still a single event.
3. RUN, pause when prescaler = 4 -> no tick, state PAUSE; press start -> first tick on the first RUN cycle, then every 5 cycles.
4. RUN, lap -> display_Hold 1, ticks continue every 5 cycles; lap again -> display_Hold 0, state RUN.
5. PAUSE, lap -> one clear_Counters pulse, state IDLE, prescaler 0; IDLE + lap -> one more clear pulse, state stays IDLE.
6. Start and lap pressed on the same cycle in RUN -> PAUSE, no clear; assert reset mid-LAP -> outputs 0 immediately, power-on clear pulse after release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Definitions shared by the stopwatch controller and the display block that
// decodes timer_State.
//   ST_IDLE / ST_RUN / ST_PAUSE / ST_LAP : 2-bit FSM state encodings
//   TICK_HZ_DEFAULT                      : default count tick rate (1/100 s)
//   is_counting()                        : true in the states where time advances
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_LAP   = 2'd3;

    localparam int TICK_HZ_DEFAULT = 100;

    // Lap mode keeps counting underneath the frozen display.
    function automatic logic is_counting(input logic [1:0] state);
        return (state == ST_RUN) || (state == ST_LAP);
    endfunction

endpackage

// File: rtl/button_edge_sync.sv
// -----------------------------------------------------------------------------
// button_edge_sync
// Brings a raw, asynchronous button level into the clock domain and turns each
// press into a single-cycle registered pulse.
//   clock       : system clock, rising edge
//   reset       : asynchronous, active-high
//   button_in   : raw button level, active-high
//   press_pulse : one-cycle pulse, registered two edges after the edge that
//                 first samples the button high; a held button gives one pulse
// -----------------------------------------------------------------------------
module button_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic button_in,
    output logic press_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic pulse_q, pulse_d;

    always_comb begin
        sync1_d = button_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        // Rising edge of the synchronised level, registered so the FSM never
        // sees a combinational path from the button.
        pulse_d = sync2_q & ~prev_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would collapse
    // the synchroniser chain into a single stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign press_pulse = pulse_q;

endmodule

// File: rtl/stopwatch_controller.sv
// -----------------------------------------------------------------------------
// stopwatch_controller
// Control FSM for the BCD counter chain: derives the count tick, conditions the
// two buttons and sequences IDLE / RUN / PAUSE / LAP.
//   clock          : system clock, rising edge
//   reset          : asynchronous, active-high
//   start_Stop     : raw start/stop button level
//   lap_Reset      : raw lap/reset button level
//   count_Enable   : one-cycle tick to the least-significant BCD counter
//   clear_Counters : one-cycle clear pulse to every BCD counter
//   display_Hold   : high while the display latches are frozen (LAP)
//   timer_State    : current FSM state encoding
// -----------------------------------------------------------------------------
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int CLOCK_HZ = 50000000,
    parameter int TICK_HZ  = TICK_HZ_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_Stop,
    input  logic       lap_Reset,
    output logic       count_Enable,
    output logic       clear_Counters,
    output logic       display_Hold,
    output logic [1:0] timer_State
);

    localparam int DIV = CLOCK_HZ / TICK_HZ;
    localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("stopwatch_controller: CLOCK_HZ/TICK_HZ must be at least 2");
        end
    endgenerate

    logic start_ev;
    logic lap_pulse;
    logic lap_ev;

    button_edge_sync u_start_sync (
        .clock       (clock),
        .reset       (reset),
        .button_in   (start_Stop),
        .press_pulse (start_ev)
    );

    button_edge_sync u_lap_sync (
        .clock       (clock),
        .reset       (reset),
        .button_in   (lap_Reset),
        .press_pulse (lap_pulse)
    );

    // Start has priority: a lap press in the same cycle is dropped.
    assign lap_ev = lap_pulse & ~start_ev;

    logic [1:0]    state_q,        state_d;
    logic [PW-1:0] presc_q,        presc_d;
    logic          count_enable_q, count_enable_d;
    logic          clear_q,        clear_d;
    logic          hold_q,         hold_d;
    logic          init_done_q,    init_done_d;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        presc_d        = presc_q;
        count_enable_d = 1'b0;
        // The first edge after reset issues the power-on clear.
        clear_d        = ~init_done_q;
        init_done_d    = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start_ev) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end else if (lap_ev) begin
                    clear_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (start_ev)    state_d = ST_PAUSE;
                else if (lap_ev) state_d = ST_LAP;
            end
            ST_LAP: begin
                if (start_ev)    state_d = ST_PAUSE;
                else if (lap_ev) state_d = ST_RUN;
            end
            ST_PAUSE: begin
                // Resume keeps the held prescaler so no fraction of a tick is lost.
                if (start_ev) begin
                    state_d = ST_RUN;
                end else if (lap_ev) begin
                    state_d = ST_IDLE;
                    clear_d = 1'b1;
                    presc_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Advance only while counting both before and after this edge: the edge
        // into PAUSE freezes the prescaler, so a pending wrap is deferred to
        // the first cycle back in RUN instead of being lost.
        if (is_counting(state_q) && is_counting(state_d)) begin
            if (presc_q == PRESC_MAX) begin
                presc_d        = '0;
                count_enable_d = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        hold_d = (state_d == ST_LAP);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            presc_q        <= '0;
            count_enable_q <= 1'b0;
            clear_q        <= 1'b0;
            hold_q         <= 1'b0;
            init_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            count_enable_q <= count_enable_d;
            clear_q        <= clear_d;
            hold_q         <= hold_d;
            init_done_q    <= init_done_d;
        end
    end

    assign count_Enable   = count_enable_q;
    assign clear_Counters = clear_q;
    assign display_Hold   = hold_q;
    assign timer_State    = state_q;

endmodule
